// File: rtl/usb_rx_unstuff.sv
// usb_rx_unstuff: receive-path stage behind the DP/DM line decoder.
// NRZI-decodes the line bit, removes stuffed zeros, assembles bytes LSB-first
// and reports packet status (byte count, stuffing/alignment errors, CRC) at EOP.
// Optional feature macro: RX_CRC16_CHECK_EN builds the CRC16 residual check;
// without it crc_ok simply reads 1 on every pkt_done.
module usb_rx_unstuff #(
    parameter int MAX_BYTES = 15
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       in_bit,
    input  logic       rx_active,
    input  logic       rx_eop,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic [3:0] byte_count,
    output logic       pkt_done,
    output logic       stuff_err,
    output logic       align_err,
    output logic       crc_ok
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RECV = 2'd1;
    localparam logic [1:0] ST_ERR  = 2'd2;
    localparam logic [3:0] CNT_MAX = 4'(MAX_BYTES);

    logic [1:0]  state_q, state_d;
    logic        prev_level_q, prev_level_d;
    logic [2:0]  ones_cnt_q, ones_cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [7:0]  byte_out_q, byte_out_d;
    logic        byte_valid_q, byte_valid_d;
    logic [3:0]  byte_count_q, byte_count_d;
    logic        pkt_done_q, pkt_done_d;
    logic        stuff_err_q, stuff_err_d;
    logic        align_err_q, align_err_d;
    logic        crc_ok_q, crc_ok_d;
`ifdef RX_CRC16_CHECK_EN
    logic [15:0] crc_q, crc_d;
`endif
    logic        dec_bit;
    logic        pkt_clear;
    logic        accept;

    // Next-state logic: packet start clears status, then EOP or the current bit is processed
    always_comb begin
        state_d      = state_q;
        prev_level_d = prev_level_q;
        ones_cnt_d   = ones_cnt_q;
        bit_idx_d    = bit_idx_q;
        shreg_d      = shreg_q;
        byte_out_d   = byte_out_q;
        byte_valid_d = 1'b0;
        byte_count_d = byte_count_q;
        pkt_done_d   = 1'b0;
        stuff_err_d  = stuff_err_q;
        align_err_d  = align_err_q;
        crc_ok_d     = crc_ok_q;
`ifdef RX_CRC16_CHECK_EN
        crc_d        = crc_q;
`endif
        // Same level as the previous bit means a decoded one.
        dec_bit   = (in_bit == prev_level_q);
        // Leaving IDLE (start of payload, or an EOP with no payload) starts a fresh packet.
        pkt_clear = (state_q == ST_IDLE) && (rx_active || rx_eop);
        // EOP has priority over a simultaneous payload bit; ERR swallows bits.
        accept    = rx_active && !rx_eop && (state_q != ST_ERR);

        // Track the idle line so the first payload bit decodes against the real level.
        if (!rx_active) begin
            prev_level_d = in_bit;
        end

        if (pkt_clear) begin
            ones_cnt_d   = 3'd0;
            bit_idx_d    = 3'd0;
            byte_count_d = 4'd0;
            stuff_err_d  = 1'b0;
            align_err_d  = 1'b0;
            crc_ok_d     = 1'b0;
`ifdef RX_CRC16_CHECK_EN
            crc_d        = 16'hFFFF;
`endif
        end

        if (rx_eop) begin
            state_d     = ST_IDLE;
            pkt_done_d  = 1'b1;
            // A partial byte is dropped; only flag it.
            align_err_d = (bit_idx_d != 3'd0);
`ifdef RX_CRC16_CHECK_EN
            crc_ok_d    = (crc_d == 16'h800D) && !stuff_err_d && (bit_idx_d == 3'd0);
`else
            crc_ok_d    = 1'b1;
`endif
        end else if (accept) begin
            state_d      = ST_RECV;
            prev_level_d = in_bit;
            if (ones_cnt_d == 3'd6) begin
                // After six ones the transmitter must insert a zero.
                if (dec_bit) begin
                    state_d     = ST_ERR;
                    stuff_err_d = 1'b1;
                end else begin
                    ones_cnt_d = 3'd0;
                end
            end else begin
                ones_cnt_d = dec_bit ? (ones_cnt_d + 3'd1) : 3'd0;
                shreg_d    = {dec_bit, shreg_q[7:1]};
`ifdef RX_CRC16_CHECK_EN
                crc_d      = {crc_d[14:0], 1'b0} ^ ((dec_bit ^ crc_d[15]) ? 16'h8005 : 16'h0000);
`endif
                if (bit_idx_d == 3'd7) begin
                    byte_out_d   = {dec_bit, shreg_q[7:1]};
                    byte_valid_d = 1'b1;
                    if (byte_count_d != CNT_MAX) begin
                        byte_count_d = byte_count_d + 4'd1;
                    end
                end
                bit_idx_d = bit_idx_d + 3'd1;
            end
        end
    end

    // Control and status registers with asynchronous active-low reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            prev_level_q <= 1'b1;
            ones_cnt_q   <= 3'd0;
            bit_idx_q    <= 3'd0;
            byte_out_q   <= 8'h00;
            byte_valid_q <= 1'b0;
            byte_count_q <= 4'd0;
            pkt_done_q   <= 1'b0;
            stuff_err_q  <= 1'b0;
            align_err_q  <= 1'b0;
            crc_ok_q     <= 1'b0;
`ifdef RX_CRC16_CHECK_EN
            crc_q        <= 16'hFFFF;
`endif
        end else begin
            state_q      <= state_d;
            prev_level_q <= prev_level_d;
            ones_cnt_q   <= ones_cnt_d;
            bit_idx_q    <= bit_idx_d;
            byte_out_q   <= byte_out_d;
            byte_valid_q <= byte_valid_d;
            byte_count_q <= byte_count_d;
            pkt_done_q   <= pkt_done_d;
            stuff_err_q  <= stuff_err_d;
            align_err_q  <= align_err_d;
            crc_ok_q     <= crc_ok_d;
`ifdef RX_CRC16_CHECK_EN
            crc_q        <= crc_d;
`endif
        end
    end

    // Byte shift register is pure data; it is never observed before eight bits fill it
    always_ff @(posedge clock) begin
        shreg_q <= shreg_d;
    end

    assign byte_out   = byte_out_q;
    assign byte_valid = byte_valid_q;
    assign byte_count = byte_count_q;
    assign pkt_done   = pkt_done_q;
    assign stuff_err  = stuff_err_q;
    assign align_err  = align_err_q;
    assign crc_ok     = crc_ok_q;

endmodule

// File: tb/tb_usb_rx_unstuff.sv
// Testbench for usb_rx_unstuff: packets are described as payload bytes, then
// stuffed and NRZI-encoded by the bench; expectations come from the payload.
module tb_usb_rx_unstuff;
    logic       clock = 1'b0;
    logic       reset_n;
    logic       in_bit;
    logic       rx_active;
    logic       rx_eop;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic [3:0] byte_count;
    logic       pkt_done;
    logic       stuff_err;
    logic       align_err;
    logic       crc_ok;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    usb_rx_unstuff #(.MAX_BYTES(15)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_bit     (in_bit),
        .rx_active  (rx_active),
        .rx_eop     (rx_eop),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_count (byte_count),
        .pkt_done   (pkt_done),
        .stuff_err  (stuff_err),
        .align_err  (align_err),
        .crc_ok     (crc_ok)
    );

    typedef struct {
        int         nb;       // payload bytes
        int         xb;       // trailing partial bits
        bit         ff;       // payload all 8'hFF instead of 1,2,3..
        bit         add_crc;  // append correct CRC16
        bit         flip;     // flip bit 0 of byte 0 after CRC is computed
        logic [3:0] ecnt;
        bit         ealign;
        int         ecrc;     // 0/1 expected with CRC check, 2 = use model
    } vec_t;

    logic [7:0] pbytes[$];   // bytes as they appear on the wire
    bit         dbits[$];    // data bits in wire order
    bit         lbits[$];    // line levels, one per cycle
    int         lmark[$];    // byte index completed by this line bit, else -1
    bit         enc_lvl;
    int         enc_ones;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic cycle(input bit act, input bit eop, input bit lvl);
        rx_active = act;
        rx_eop    = eop;
        in_bit    = lvl;
        @(posedge clock);
        #1;
    endtask

    // Reflected CRC-16/USB (poly 0xA001, LSB first); returns the value to transmit.
    function automatic logic [15:0] crc16_usb();
        logic [15:0] r = 16'hFFFF;
        foreach (pbytes[k]) begin
            for (int i = 0; i < 8; i++)
                r = (r[0] ^ pbytes[k][i]) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        end
        return ~r;
    endfunction

    // Residue of CRC-16/USB over all data bits, including the received CRC.
    function automatic bit crc_good();
        logic [15:0] r = 16'hFFFF;
        foreach (dbits[j])
            r = (r[0] ^ dbits[j]) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        return r == 16'hB001;
    endfunction

    function automatic bit exp_crc(input bit ealign, input bit estuff);
`ifdef RX_CRC16_CHECK_EN
        return !ealign && !estuff && crc_good();
`else
        return ealign | estuff | 1'b1;
`endif
    endfunction

    task automatic enc_line(input bit d, input int mark);
        enc_lvl = d ? enc_lvl : ~enc_lvl;
        lbits.push_back(enc_lvl);
        lmark.push_back(mark);
    endtask

    // Data bit: NRZI-encoded, with a zero stuffed after every six ones.
    task automatic enc_data(input bit d, input int mark);
        dbits.push_back(d);
        enc_line(d, mark);
        enc_ones = d ? enc_ones + 1 : 0;
        if (enc_ones == 6) begin
            enc_line(1'b0, -1);
            enc_ones = 0;
        end
    endtask

    task automatic build(input int xb);
        enc_lvl  = 1'b1;
        enc_ones = 0;
        dbits.delete();
        lbits.delete();
        lmark.delete();
        foreach (pbytes[k])
            for (int i = 0; i < 8; i++) enc_data(pbytes[k][i], (i == 7) ? k : -1);
        for (int i = 0; i < xb; i++) enc_data((i % 2) == 0, -1);
    endtask

    task automatic run_bits(input string nm, input int upto);
        for (int p = 0; p < upto; p++) begin
            cycle(1'b1, 1'b0, lbits[p]);
            chk({nm, "/valid"}, byte_valid, lmark[p] >= 0);
            chk({nm, "/done_low"}, pkt_done, 0);
            if (lmark[p] >= 0) chk({nm, "/byte"}, byte_out, pbytes[lmark[p]]);
        end
    endtask

    task automatic run_packet(input string nm, input logic [3:0] ecnt, input bit ealign,
                              input bit estuff, input bit ecrc);
        run_bits(nm, lbits.size());
        cycle(1'b0, 1'b1, 1'b1);
        chk({nm, "/pkt_done"}, pkt_done, 1);
        chk({nm, "/eop_valid"}, byte_valid, 0);
        chk({nm, "/count"}, byte_count, ecnt);
        chk({nm, "/align"}, align_err, ealign);
        chk({nm, "/stuff"}, stuff_err, estuff);
        chk({nm, "/crc_ok"}, crc_ok, ecrc);
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "/byte_out"}, byte_out, 8'h00);
        chk({nm, "/byte_valid"}, byte_valid, 0);
        chk({nm, "/byte_count"}, byte_count, 0);
        chk({nm, "/pkt_done"}, pkt_done, 0);
        chk({nm, "/stuff_err"}, stuff_err, 0);
        chk({nm, "/align_err"}, align_err, 0);
        chk({nm, "/crc_ok"}, crc_ok, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[8];
        logic [15:0] c;
        logic [7:0]  tmp;
        int          ecrc_v;
        bit          ec;

        tbl[0] = '{8,  0, 1'b0, 1'b1, 1'b0, 4'd10, 1'b0, 1};  // 01..08 + CRC
        tbl[1] = '{8,  0, 1'b0, 1'b1, 1'b1, 4'd10, 1'b0, 0};  // corrupted payload
        tbl[2] = '{2,  0, 1'b1, 1'b0, 1'b0, 4'd2,  1'b0, 2};  // FF FF, stuffing
        tbl[3] = '{1,  4, 1'b0, 1'b0, 1'b0, 4'd1,  1'b1, 0};  // 12 data bits
        tbl[4] = '{20, 0, 1'b0, 1'b0, 1'b0, 4'd15, 1'b0, 2};  // count saturation
        tbl[5] = '{0,  0, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 0};  // EOP in IDLE
        tbl[6] = '{3,  0, 1'b1, 1'b1, 1'b0, 4'd5,  1'b0, 1};  // FF x3 + CRC
        tbl[7] = '{0,  3, 1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 0};  // partial bits only

        reset_n   = 1'b0;
        rx_active = 1'b0;
        rx_eop    = 1'b0;
        in_bit    = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk_reset_vals("reset");
        reset_n = 1'b1;
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);

        // Table rows run back to back: next packet starts in the pkt_done cycle.
        foreach (tbl[r]) begin
            pbytes.delete();
            for (int i = 0; i < tbl[r].nb; i++)
                pbytes.push_back(tbl[r].ff ? 8'hFF : 8'(i + 1));
            if (tbl[r].add_crc) begin
                c = crc16_usb();
                pbytes.push_back(c[7:0]);
                pbytes.push_back(c[15:8]);
            end
            if (tbl[r].flip) begin
                tmp       = pbytes[0];
                tmp[0]    = ~tmp[0];
                pbytes[0] = tmp;
            end
            build(tbl[r].xb);
`ifdef RX_CRC16_CHECK_EN
            ecrc_v = (tbl[r].ecrc == 2) ? int'(exp_crc(tbl[r].ealign, 1'b0)) : tbl[r].ecrc;
`else
            ecrc_v = 1;
`endif
            run_packet($sformatf("row%0d", r), tbl[r].ecnt, tbl[r].ealign, 1'b0, ecrc_v != 0);
        end

        // Seven decoded ones mid-byte: stuffing error, no further bytes.
        pbytes.delete();
        pbytes.push_back(8'hA5);
        build(0);
        enc_line(1'b0, -1);
        for (int i = 0; i < 7; i++) enc_line(1'b1, -1);
        for (int i = 0; i < 10; i++) enc_line(i[0], -1);
        run_packet("stuff_err", 4'd1, 1'b1, 1'b1, exp_crc(1'b1, 1'b1));
        cycle(1'b0, 1'b0, 1'b1);

        // Reset after three bytes of a packet: outputs clear, no pkt_done follows.
        pbytes.delete();
        pbytes.push_back(8'h11);
        pbytes.push_back(8'h22);
        pbytes.push_back(8'h33);
        pbytes.push_back(8'h44);
        build(0);
        begin
            int upto = 0;
            foreach (lmark[p]) if (lmark[p] == 2) upto = p + 1;
            run_bits("pre_reset", upto);
        end
        reset_n   = 1'b0;
        rx_active = 1'b0;
        in_bit    = 1'b1;
        #1;
        chk_reset_vals("mid_reset");
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b1);
            chk("post_reset/pkt_done", pkt_done, 0);
        end
        pbytes.delete();
        pbytes.push_back(8'h5A);
        pbytes.push_back(8'hC3);
        build(0);
        run_packet("after_reset", 4'd2, 1'b0, 1'b0, exp_crc(1'b0, 1'b0));

        // Random packets against the payload-level model.
        for (int n = 0; n < 40; n++) begin
            int nb = $urandom_range(0, 20);
            int xb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            int gap = $urandom_range(0, 2);
            pbytes.delete();
            for (int i = 0; i < nb; i++)
                pbytes.push_back($urandom_range(0, 1) ? 8'hFF : 8'($urandom));
            if (nb > 0 && $urandom_range(0, 1) == 1) begin
                c = crc16_usb();
                pbytes.push_back(c[7:0]);
                pbytes.push_back(c[15:8]);
            end
            build(xb);
            ec = exp_crc(xb != 0, 1'b0);
            run_packet($sformatf("rand%0d", n),
                       (pbytes.size() > 15) ? 4'd15 : 4'(pbytes.size()),
                       xb != 0, 1'b0, ec);
            for (int g = 0; g < gap; g++) begin
                cycle(1'b0, 1'b0, 1'b1);
                chk("gap/pkt_done", pkt_done, 0);
                chk("gap/valid", byte_valid, 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
